muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_pkg.sv | 51 +++++
 rtl/muldiv_iter.sv | 77 +++++++
 rtl/muldiv_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
//
// Purpose: definitions shared by the RV32M multiply/divide sequencer, its
// iterative datapath and the ALU decoder.
//   - 5-bit ALU opcode constants (base ALU ops plus the eight M-extension ops)
//   - sequencer state encoding (3 bits)
//   - signed-overflow operand constants for 32-bit divide
//   - helper predicate that recognises an M-extension opcode
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

  typedef logic [4:0] opcode_t;

  // Base ALU opcodes. The sequencer only needs to reject these.
  localparam opcode_t OP_ADD    = 5'h00;
  localparam opcode_t OP_SUB    = 5'h01;
  localparam opcode_t OP_AND    = 5'h02;
  localparam opcode_t OP_OR     = 5'h03;
  localparam opcode_t OP_XOR    = 5'h04;

  // M-extension opcodes, kept in one aligned block of eight.
  localparam opcode_t OP_MUL    = 5'h10;
  localparam opcode_t OP_MULH   = 5'h11;
  localparam opcode_t OP_MULHSU = 5'h12;
  localparam opcode_t OP_MULHU  = 5'h13;
  localparam opcode_t OP_DIV    = 5'h14;
  localparam opcode_t OP_DIVU   = 5'h15;
  localparam opcode_t OP_REM    = 5'h16;
  localparam opcode_t OP_REMU   = 5'h17;

  // Sequencer state encoding.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PREP   = 3'd1;
  localparam logic [2:0] CALC   = 3'd2;
  localparam logic [2:0] FIX    = 3'd3;
  localparam logic [2:0] DONE_S = 3'd4;

  // Operands of the single signed-divide overflow case (XLEN = 32).
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  // True for the eight opcodes the sequencer executes.
  function automatic logic is_mop(input opcode_t op);
    return (op == OP_MUL)  || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_MULHU) || (op == OP_DIV)  || (op == OP_DIVU)   ||
           (op == OP_REM)  || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
//
// Purpose: 2*XLEN accumulator with one iteration step of either an unsigned
// shift-add multiply (LSB first) or an unsigned restoring divide (MSB first).
// Operands arrive as magnitudes; sign handling lives in the sequencer.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   reset        in   synchronous active-high reset, clears all state
//   load         in   load accumulator {0, init_lo} and latch init_operand
//   step         in   perform one iteration on the accumulator
//   div_mode     in   0 = multiply step, 1 = divide step
//   init_lo      in   multiplier (multiply) or dividend (divide) magnitude
//   init_operand in   multiplicand (multiply) or divisor (divide) magnitude
//   acc          out  accumulator: multiply -> {hi, lo} product,
//                     divide -> {remainder, quotient}
// -----------------------------------------------------------------------------
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   init_lo,
  input  logic [XLEN-1:0]   init_operand,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;

  // One iteration.
  // Multiply: the low half holds the remaining multiplier bits; when the
  // current LSB is set the multiplicand is added into the high half, then the
  // whole accumulator shifts right with the add carry entering at the top.
  // Divide: the partial remainder (high half) shifts left taking the next
  // dividend bit; the trial subtract is XLEN+1 bits so its MSB is a clean
  // borrow. On no borrow the difference is kept and a 1 enters the quotient.
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = trial - {1'b0, operand};
    acc_next = acc;
    if (div_mode) begin
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {add_sum, acc[XLEN-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      operand <= '0;
    end else if (load) begin
      acc     <= {{XLEN{1'b0}}, init_lo};
      operand <= init_operand;
    end else if (step) begin
      acc     <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose: multi-cycle controller for the RV32M operations MUL, MULH, MULHSU,
// MULHU, DIV, DIVU, REM and REMU. Runs IDLE -> PREP -> CALC -> FIX -> DONE_S,
// converting operands to magnitudes, iterating XLEN times in muldiv_iter and
// restoring the sign / selecting the result half at the end. Divide by zero
// and signed overflow can skip CALC entirely (FAST_DIV).
//
// Parameters:
//   XLEN      operand/result width, also the number of CALC iterations
//   FAST_DIV  1 = divide-by-zero and signed overflow go PREP -> FIX directly
//
// Ports:
//   CLK     in   clock, all state on rising edge
//   RESET   in   synchronous active-high reset
//   START   in   operation request, sampled only in IDLE
//   KILL    in   pipeline flush, aborts the current or requested operation
//   OPCODE  in   5-bit ALU opcode; only the eight M-ops are accepted
//   DATA1   in   rs1 (multiplicand / dividend)
//   DATA2   in   rs2 (multiplier / divisor)
//   RESULT  out  registered result, updated only when entering DONE_S
//   BUSY    out  high from PREP through DONE_S inclusive
//   DONE    out  one-cycle completion pulse (DONE_S)
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_DIV = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            KILL,
  input  logic [4:0]      OPCODE,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] NEG_ONE_X = {XLEN{1'b1}};

  logic [2:0]        state;
  logic [CW-1:0]     counter;
  opcode_t           op_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   b_reg;
  logic              res_neg;
  logic              fast_path;
  logic              fast_zero;
  logic [XLEN-1:0]   result_reg;

  logic              accept;
  logic              signed_a;
  logic              signed_b;
  logic              is_div;
  logic              is_rem;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              b_zero;
  logic              overflow;
  logic              sign_next;
  logic              take_fast;

  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_result;

  // A request is taken only from IDLE, and a simultaneous flush cancels it.
  assign accept = (state == IDLE) && START && !KILL && is_mop(OPCODE);

  // Decode the latched opcode into signedness and divide/remainder class.
  // MULHSU treats only rs1 as signed.
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    is_div   = 1'b0;
    is_rem   = 1'b0;
    case (op_reg)
      OP_MUL, OP_MULH: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      OP_MULHSU: begin
        signed_a = 1'b1;
      end
      OP_DIV: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
        is_div   = 1'b1;
      end
      OP_DIVU: begin
        is_div   = 1'b1;
      end
      OP_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
        is_div   = 1'b1;
        is_rem   = 1'b1;
      end
      OP_REMU: begin
        is_div   = 1'b1;
        is_rem   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Operand magnitudes, result sign and the special divide cases.
  // A divide by zero must come out as all ones regardless of operand signs,
  // so the quotient is never negated in that case; the remainder still takes
  // the dividend's sign, which turns |rs1| back into rs1. Signed overflow
  // needs no special sign rule: |INT_MIN| / 1 with sign s1^s2 = 0 is INT_MIN.
  always_comb begin
    neg_a     = signed_a && a_reg[XLEN-1];
    neg_b     = signed_b && b_reg[XLEN-1];
    mag_a     = neg_a ? -a_reg : a_reg;
    mag_b     = neg_b ? -b_reg : b_reg;
    b_zero    = (b_reg == '0);
    overflow  = is_div && signed_b && (a_reg == INT_MIN_X) && (b_reg == NEG_ONE_X);
    sign_next = 1'b0;
    if (!is_div) begin
      sign_next = neg_a ^ neg_b;
    end else if (is_rem) begin
      sign_next = neg_a;
    end else if (!b_zero) begin
      sign_next = neg_a ^ neg_b;
    end
    take_fast = (FAST_DIV != 0) && is_div && (b_zero || overflow);
  end

  // Multiply walks the multiplier (rs2) through the low half and adds the
  // multiplicand; divide walks the dividend (rs1) and subtracts the divisor.
  muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk          (CLK),
    .reset        (RESET),
    .load         (state == PREP),
    .step         (state == CALC),
    .div_mode     (is_div),
    .init_lo      (is_div ? mag_a : mag_b),
    .init_operand (is_div ? mag_b : mag_a),
    .acc          (acc)
  );

  // Sign restoration and result select in FIX. The fast path ignores the
  // accumulator and produces the architecturally defined special values.
  always_comb begin
    prod       = res_neg ? -acc : acc;
    quo        = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem        = res_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_result = '0;
    if (fast_path) begin
      if (fast_zero) begin
        fix_result = is_rem ? a_reg : NEG_ONE_X;
      end else begin
        fix_result = is_rem ? '0 : INT_MIN_X;
      end
    end else begin
      case (op_reg)
        OP_MUL:                       fix_result = prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              fix_result = quo;
        OP_REM, OP_REMU:              fix_result = rem;
        default:                      fix_result = '0;
      endcase
    end
  end

  // Sequencer FSM. Operands are captured on the accepting edge so the
  // pipeline may change DATA1/DATA2 while stalled. KILL in any busy state
  // returns to IDLE without touching RESULT; RESULT only loads on FIX->DONE_S.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      counter    <= '0;
      op_reg     <= OP_ADD;
      a_reg      <= '0;
      b_reg      <= '0;
      res_neg    <= 1'b0;
      fast_path  <= 1'b0;
      fast_zero  <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= PREP;
            op_reg <= OPCODE;
            a_reg  <= DATA1;
            b_reg  <= DATA2;
          end
        end
        PREP: begin
          if (KILL) begin
            state <= IDLE;
          end else begin
            res_neg   <= sign_next;
            fast_path <= take_fast;
            fast_zero <= b_zero;
            if (take_fast) begin
              state <= FIX;
            end else begin
              state   <= CALC;
              counter <= CW'(XLEN - 1);
            end
          end
        end
        CALC: begin
          if (KILL) begin
            state <= IDLE;
          end else if (counter == '0) begin
            state <= FIX;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        FIX: begin
          if (KILL) begin
            state <= IDLE;
          end else begin
            result_reg <= fix_result;
            state      <= DONE_S;
          end
        end
        DONE_S: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign RESULT = result_reg;
  assign BUSY   = (state != IDLE);
  assign DONE   = (state == DONE_S);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer (XLEN=32, FAST_DIV=1): a table of
// directed vectors, hand-written flush/reset/restart sequences and random
// operations compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int XLEN     = 32;
  localparam int LAT_FULL = XLEN + 3;
  localparam int LAT_FAST = 3;
  localparam int MAX_WAIT = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        kill;
  logic [4:0]  opcode;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    string       name;
    opcode_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  muldiv_sequencer #(
    .XLEN     (XLEN),
    .FAST_DIV (1)
  ) dut (
    .CLK    (clk),
    .RESET  (reset),
    .START  (start),
    .KILL   (kill),
    .OPCODE (opcode),
    .DATA1  (data1),
    .DATA2  (data2),
    .RESULT (result),
    .BUSY   (busy),
    .DONE   (done)
  );

  always #5 clk = ~clk;

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] refModel(input opcode_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'h0) return NEG_ONE;
        if (a == INT_MIN && b == NEG_ONE) return INT_MIN;
        p = 64'(sa / sb);
        return p[31:0];
      end
      OP_REM: begin
        if (b == 32'h0) return a;
        if (a == INT_MIN && b == NEG_ONE) return 32'h0;
        p = 64'(sa % sb);
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'h0) return NEG_ONE;
        p = 64'(ua / ub);
        return p[31:0];
      end
      OP_REMU: begin
        if (b == 32'h0) return a;
        p = 64'(ua % ub);
        return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  // Divides by zero and the signed overflow case skip the iteration.
  function automatic int refLatency(input opcode_t op, input logic [31:0] a,
                                    input logic [31:0] b);
    bit div_op;
    bit signed_op;
    div_op    = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    signed_op = (op == OP_DIV) || (op == OP_REM);
    if (div_op && (b == 32'h0 || (signed_op && a == INT_MIN && b == NEG_ONE)))
      return LAT_FAST;
    return LAT_FULL;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return INT_MIN;
      2:       return NEG_ONE;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Issue one op, then watch until DONE. lat counts cycles from PREP (1)
  // to the DONE cycle; 0 means DONE never came within the budget.
  task automatic applyStimulus(input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    data1  = a;
    data2  = b;
    @(negedge clk);
    start   = 1'b0;
    data1   = $urandom;
    data2   = $urandom;
    lat     = 0;
    busy_ok = 1'b1;
    res     = '0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string name, input opcode_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    bit          busy_ok;
    applyStimulus(op, a, b, res, lat, busy_ok);
    checkOutput({name, ".result"}, res, exp_res);
    checkOutput({name, ".latency"}, lat, exp_lat);
    checkOutput({name, ".busy"}, {31'b0, busy_ok}, 32'h1);
    @(negedge clk);
    checkOutput({name, ".idle"}, {30'b0, busy, done}, 32'h0);
    last_res = exp_res;
  endtask

  initial begin
    int          lat;
    bit          saw;
    logic [31:0] res;
    opcode_t     rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset  = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    opcode = OP_ADD;
    data1  = '0;
    data2  = '0;

    vecs[0]  = '{"mul_7x-3",     OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_FULL};
    vecs[1]  = '{"mulh_7x-3",    OP_MULH,   32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT_FULL};
    vecs[2]  = '{"mulhu_max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL};
    vecs[3]  = '{"mulhsu_-1x2",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT_FULL};
    vecs[4]  = '{"div_-7/2",     OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT_FULL};
    vecs[5]  = '{"rem_-7/2",     OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT_FULL};
    vecs[6]  = '{"divu_100/7",   OP_DIVU,   32'd100,      32'd7,        32'd14,        LAT_FULL};
    vecs[7]  = '{"remu_100/7",   OP_REMU,   32'd100,      32'd7,        32'd2,         LAT_FULL};
    vecs[8]  = '{"div_5/0",      OP_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, LAT_FAST};
    vecs[9]  = '{"rem_5/0",      OP_REM,    32'd5,        32'd0,        32'd5,         LAT_FAST};
    vecs[10] = '{"div_ovf",      OP_DIV,    INT_MIN,      NEG_ONE,      INT_MIN,       LAT_FAST};
    vecs[11] = '{"rem_ovf",      OP_REM,    INT_MIN,      NEG_ONE,      32'd0,         LAT_FAST};
    vecs[12] = '{"divu_x/0",     OP_DIVU,   32'h1234_5678, 32'd0,        32'hFFFF_FFFF, LAT_FAST};
    vecs[13] = '{"remu_neg/0",   OP_REMU,   32'h8000_0001, 32'd0,        32'h8000_0001, LAT_FAST};
    vecs[14] = '{"mulh_min2",    OP_MULH,   INT_MIN,      INT_MIN,      32'h4000_0000, LAT_FULL};
    vecs[15] = '{"rem_7/-2",     OP_REM,    32'd7,        32'hFFFF_FFFE, 32'd1,         LAT_FULL};

    repeat (3) @(negedge clk);
    checkOutput("reset.result", result, 32'h0);
    checkOutput("reset.busy", {31'b0, busy}, 32'h0);
    checkOutput("reset.done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
    end

    // Flush during the tenth CALC cycle.
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; data1 = 32'd123; data2 = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("kill.busy_before", {31'b0, busy}, 32'h1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checkOutput("kill.busy", {31'b0, busy}, 32'h0);
    checkOutput("kill.done", {31'b0, done}, 32'h0);
    checkOutput("kill.result", result, last_res);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    checkOutput("kill.no_done", {31'b0, saw}, 32'h0);

    // START and KILL together in IDLE.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; opcode = OP_DIVU; data1 = 32'd100; data2 = 32'd7;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      if (done || busy) saw = 1'b1;
      @(negedge clk);
    end
    checkOutput("startkill.ignored", {31'b0, saw}, 32'h0);
    checkOutput("startkill.result", result, last_res);

    // A second START while busy must be dropped.
    @(negedge clk);
    start = 1'b1; opcode = OP_DIVU; data1 = 32'd100; data2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 0; res = '0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      if (i == 5) begin
        start = 1'b1; opcode = OP_MUL; data1 = 32'd3; data2 = 32'd4;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("restart.result", res, 32'd14);
    checkOutput("restart.latency", lat, LAT_FULL);
    last_res = 32'd14;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    checkOutput("restart.no_queue", {31'b0, saw}, 32'h0);

    // Non-M opcode is not accepted.
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; data1 = 32'd1; data2 = 32'd2;
    @(negedge clk);
    start = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      if (busy || done) saw = 1'b1;
      @(negedge clk);
    end
    checkOutput("add.ignored", {31'b0, saw}, 32'h0);
    checkOutput("add.result", result, last_res);

    // Reset in the middle of CALC, then a normal operation.
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; data1 = 32'h1234; data2 = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset.result", result, 32'h0);
    checkOutput("midreset.busy", {31'b0, busy}, 32'h0);
    checkOutput("midreset.done", {31'b0, done}, 32'h0);
    runOp("post_reset_mul_3x4", OP_MUL, 32'd3, 32'd4, 32'd12, LAT_FULL);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = opcode_t'(OP_MUL + 5'($urandom_range(0, 7)));
      ra  = pickOperand();
      rb  = pickOperand();
      runOp($sformatf("rand%0d_op%0h", n, rop), rop, ra, rb,
            refModel(rop, ra, rb), refLatency(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
